// File: rtl/tqvp_pulse_gen_pkg.sv
// Shared definitions for the TQVP pulse generator: default register
// addresses, CTRL bit positions, FSM state encoding and small helpers.
// Optional feature: TQVP_PULSE_GEN_SEG_EN adds the 7-segment decoder helper.
package tqvp_pulse_gen_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SEG_W  = 7;

  // Default register addresses
  localparam logic [ADDR_W-1:0] ADDR_CTRL_DEF  = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_COUNT_DEF = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_HIGH_DEF  = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_LOW_DEF   = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_PRESC_DEF = 4'h4;

  // CTRL write bits
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;
  // CTRL read bits
  localparam int unsigned CTRL_BUSY_BIT  = 0;
  localparam int unsigned CTRL_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // A programmed width of zero behaves as one tick
  function automatic logic [DATA_W-1:0] clamp_width(input logic [DATA_W-1:0] w);
    return (w == '0) ? DATA_W'(1) : w;
  endfunction

`ifdef TQVP_PULSE_GEN_SEG_EN
  // Common-cathode hex digit, result bit0 = segment A .. bit6 = segment G
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction
`endif

endpackage

// File: rtl/tqvp_pulse_prescaler.sv
// Tick generator: tick is high once every (div+1) clk cycles, counting from
// the cycle after the last clear.
// Ports: clk, rst_n (sync, active-low), clear (restart the period),
//        div[7:0] (period minus one), tick (one-cycle strobe).
module tqvp_pulse_prescaler
  import tqvp_pulse_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] div,
  output logic              tick
);

  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] cnt_d;

  // Internal strobe decoded from the counter register
  assign tick = (cnt_q == div);

  // Count 0..div; div only changes together with clear, so no wrap
  always_comb begin
    cnt_d = cnt_q + DATA_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tqvp_pulse_generator.sv
// Programmable pulse-train generator with a small register interface.
// Ports: clk, rst_n (sync, active-low), ui_in (unused), uo_out (bit0 pulse,
//        bits 7:1 segment display or zero), address/data_write/data_in
//        (register write port), data_out (combinational read data).
// Optional feature: define TQVP_PULSE_GEN_SEG_EN to show remaining[3:0] as a
// hex digit on uo_out[7:1].
module tqvp_pulse_generator
  import tqvp_pulse_gen_pkg::*;
#(
  parameter logic [3:0] ADDR_CTRL  = ADDR_CTRL_DEF,
  parameter logic [3:0] ADDR_COUNT = ADDR_COUNT_DEF,
  parameter logic [3:0] ADDR_HIGH  = ADDR_HIGH_DEF,
  parameter logic [3:0] ADDR_LOW   = ADDR_LOW_DEF,
  parameter logic [3:0] ADDR_PRESC = ADDR_PRESC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] wcnt_q, wcnt_d;
  logic [DATA_W-1:0] presc_act_q, presc_act_d;
  logic [DATA_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] high_q, high_d;
  logic [DATA_W-1:0] low_q, low_d;
  logic [DATA_W-1:0] presc_q, presc_d;
  logic              done_q, done_d;
  logic              pulse_q;
  logic              busy_c;
  logic              clear_c;
  logic              tick;
  logic              start_c;
  logic              abort_c;
  logic              unused_ok;

  assign unused_ok = &{1'b0, ui_in};
  assign busy_c    = (state_q != ST_IDLE);
  assign start_c   = data_write && (address == ADDR_CTRL) && data_in[CTRL_START_BIT];
  assign abort_c   = data_write && (address == ADDR_CTRL) && data_in[CTRL_ABORT_BIT];

  tqvp_pulse_prescaler u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_c),
    .div   (presc_act_q),
    .tick  (tick)
  );

  // Next-state: register writes, phase sequencing, abort override
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    presc_act_d = presc_act_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    high_d      = high_q;
    low_d       = low_q;
    presc_d     = presc_q;
    done_d      = done_q;
    clear_c     = 1'b0;

    if (data_write) begin
      if ((address == ADDR_COUNT) && !busy_c) count_d = data_in;
      if (address == ADDR_HIGH)  high_d  = data_in;
      if (address == ADDR_LOW)   low_d   = data_in;
      if (address == ADDR_PRESC) presc_d = data_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d     = ST_HIGH;
          wcnt_d      = clamp_width(high_q);
          presc_act_d = presc_q;
          clear_c     = 1'b1;
          remaining_d = count_q;
          done_d      = 1'b0;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          if (wcnt_q == DATA_W'(1)) begin
            state_d     = ST_LOW;
            wcnt_d      = clamp_width(low_q);
            presc_act_d = presc_q;
            clear_c     = 1'b1;
            if ((count_q != '0) && (remaining_q != '0)) begin
              remaining_d = remaining_q - DATA_W'(1);
            end
          end else begin
            wcnt_d = wcnt_q - DATA_W'(1);
          end
        end
      end
      ST_LOW: begin
        if (tick) begin
          if (wcnt_q == DATA_W'(1)) begin
            // Continuous mode (N==0) never finishes on its own
            if ((count_q == '0) || (remaining_q != '0)) begin
              state_d     = ST_HIGH;
              wcnt_d      = clamp_width(high_q);
              presc_act_d = presc_q;
              clear_c     = 1'b1;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            wcnt_d = wcnt_q - DATA_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort beats start and freezes remaining/done as they were
    if (abort_c) begin
      state_d     = ST_IDLE;
      remaining_d = remaining_q;
      done_d      = done_q;
    end
  end

  // State and register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      presc_act_q <= '0;
      remaining_q <= '0;
      count_q     <= DATA_W'(1);
      high_q      <= DATA_W'(1);
      low_q       <= DATA_W'(1);
      presc_q     <= '0;
      done_q      <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      presc_act_q <= presc_act_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      high_q      <= high_d;
      low_q       <= low_d;
      presc_q     <= presc_d;
      done_q      <= done_d;
      pulse_q     <= (state_d == ST_HIGH);
    end
  end

`ifdef TQVP_PULSE_GEN_SEG_EN
  logic [SEG_W-1:0] seg_q;

  // Display register tracks remaining on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= seg_decode(4'h0);
    end else begin
      seg_q <= seg_decode(remaining_d[3:0]);
    end
  end

  assign uo_out = {seg_q, pulse_q};
`else
  assign uo_out = {7'b0, pulse_q};
`endif

  // Read mux
  always_comb begin
    data_out = '0;
    if (address == ADDR_CTRL) begin
      data_out[CTRL_BUSY_BIT] = busy_c;
      data_out[CTRL_DONE_BIT] = done_q;
    end else if (address == ADDR_COUNT) begin
      data_out = remaining_q;
    end else if (address == ADDR_HIGH) begin
      data_out = high_q;
    end else if (address == ADDR_LOW) begin
      data_out = low_q;
    end else if (address == ADDR_PRESC) begin
      data_out = presc_q;
    end
  end

endmodule
